// File: rtl/can_arb_pkg.sv
// can_arb_pkg: shared types and constants for the CAN Wishbone arbiter.
//   arb_state_e  - arbiter FSM states
//   wb_req_t     - latched downstream transfer (we/adr/dat)
//   NUM_REQ      - number of upstream requesters
//   oh2idx()     - one-hot grant to requester index
package can_arb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int REQ_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW              = 8;
  localparam int AW              = 8;
  localparam int DEFAULT_TIMEOUT = 1000;
  localparam int CNT_W           = 16;

  // Round-robin pointer after reset: "last granted" is the top requester,
  // so requester 0 is next in line.
  localparam logic [NUM_REQ-1:0] RR_INIT = {1'b1, {(NUM_REQ-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wb_req_t;

  function automatic logic [REQ_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) oh2idx = REQ_W'(i);
  endfunction

endpackage

// File: rtl/can_rr_pick.sv
// can_rr_pick: combinational round-robin picker.
//   req  - request vector
//   last - one-hot of the requester granted last (all-zero means index 0 first)
//   gnt  - one-hot winner, zero when no request
module can_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt
);

  logic [N-1:0] hi_mask, req_hi, sel;

  // Bits strictly above the last grant get first look; if none of them is
  // requesting, wrap around and take the lowest requester overall.
  assign hi_mask = ~((last << 1) - N'(1));
  assign req_hi  = req & hi_mask;
  assign sel     = (|req_hi) ? req_hi : req;
  // Isolate lowest set bit.
  assign gnt     = sel & (~sel + N'(1));

endmodule

// File: rtl/can_wb_arbiter.sv
// can_wb_arbiter: two-master Wishbone arbiter in front of a CAN core.
//   wb_clk_i / wb_rst_i       - clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i    - per-requester cycle/strobe/write enable
//   m_adr_i/m_dat_i           - requester r in bits [8r+7:8r]
//   m_dat_o/m_ack_o/m_err_o   - shared read data, per-requester ack / timeout error
//   gnt_o                     - one-hot current grant
//   wb_*                      - single downstream Wishbone port to the CAN core
module can_wb_arbiter
  import can_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NUM_REQ-1:0]    m_cyc_i,
  input  logic [NUM_REQ-1:0]    m_stb_i,
  input  logic [NUM_REQ-1:0]    m_we_i,
  input  logic [NUM_REQ*AW-1:0] m_adr_i,
  input  logic [NUM_REQ*DW-1:0] m_dat_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NUM_REQ-1:0]    m_ack_o,
  output logic [NUM_REQ-1:0]    m_err_o,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [AW-1:0]         wb_adr_o,
  output logic [DW-1:0]         wb_dat_o,
  input  logic [DW-1:0]         wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  arb_state_e                  state;
  logic [CNT_W-1:0]            cnt;
  logic [NUM_REQ-1:0]          last_gnt, pick, req_v;
  logic [REQ_W-1:0]            cur, pick_idx;
  wb_req_t                     lat;
  logic [NUM_REQ-1:0][AW-1:0]  adr_a;
  logic [NUM_REQ-1:0][DW-1:0]  dat_a;

  assign adr_a    = m_adr_i;
  assign dat_a    = m_dat_i;
  assign req_v    = m_cyc_i & m_stb_i;
  assign pick_idx = oh2idx(pick);

  can_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_v),
    .last (last_gnt),
    .gnt  (pick)
  );

  // Downstream address/data/we come only from the latched copy, so they
  // cannot move while the core is working on the transfer.
  assign wb_we_o  = lat.we;
  assign wb_adr_o = lat.adr;
  assign wb_dat_o = lat.dat;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= RR_INIT;
      cur      <= '0;
      lat      <= '0;
      gnt_o    <= '0;
      m_ack_o  <= '0;
      m_err_o  <= '0;
      m_dat_o  <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      m_ack_o <= '0;
      m_err_o <= '0;
      case (state)
        IDLE: begin
          if (|req_v) begin
            cur      <= pick_idx;
            gnt_o    <= pick;
            last_gnt <= pick;
            lat      <= '{we: m_we_i[pick_idx], adr: adr_a[pick_idx], dat: dat_a[pick_idx]};
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Abort wins over everything: the master has walked away, so it
          // must not see a stray ack or error.
          if (!m_cyc_i[cur]) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            gnt_o    <= '0;
            state    <= IDLE;
          end else if (wb_ack_i) begin
            // Checked before the timeout so a coincident ack is honoured.
            m_ack_o  <= gnt_o;
            m_dat_o  <= wb_dat_i;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= HOLD;
          end else if (cnt + CNT_W'(1) == TO_CNT) begin
            m_err_o  <= gnt_o;
            m_dat_o  <= 8'hFF;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            cnt      <= cnt + CNT_W'(1);
            state    <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          // Wait for the served master to close its cycle; a strobe left
          // high after the ack must not start a second transfer.
          if (!m_cyc_i[cur]) begin
            gnt_o <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_wb_arbiter.sv
module tb_can_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr, m_dat;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, gnt_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] err;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  can_wb_arbiter #(.TIMEOUT(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .gnt_o    (gnt_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every ack/err pulse must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (|m_ack_o || |m_err_o)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got ack=%b err=%b dat=%h expected no response",
                 m_ack_o, m_err_o, m_dat_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_resp", {20'd0, m_ack_o, m_err_o, m_dat_o}, {20'd0, e.ack, e.err, e.dat});
      end
    end
  end

  task automatic req(input int r, input logic we, input logic [7:0] adr, input logic [7:0] dat);
    m_cyc[r] = 1'b1;
    m_stb[r] = 1'b1;
    m_we[r]  = we;
    m_adr[8*r +: 8] = adr;
    m_dat[8*r +: 8] = dat;
  endtask

  task automatic drop(input int r);
    m_cyc[r] = 1'b0;
    m_stb[r] = 1'b0;
  endtask

  // Core acks in the current cycle; expectation queued for requester r.
  task automatic ack(input int r, input logic [7:0] d);
    exp_t e;
    wb_ack_i = 1'b1;
    wb_dat_i = d;
    e.ack = 2'b01 << r;
    e.err = 2'b00;
    e.dat = d;
    sb.push_back(e);
    tick();
    wb_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0;
    do_reset();
    chk("rst_gnt",    gnt_o, 2'b00);
    chk("rst_cyc",    {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("rst_dat",    m_dat_o, 8'h00);
    chk("rst_adr",    {wb_we_o, wb_adr_o, wb_dat_o}, 17'h0);
    tick();

    // Single write from requester 0, ack two cycles after cyc rises.
    req(0, 1'b1, 8'h04, 8'hA5);
    tick();
    chk("wr_cyc",  {wb_cyc_o, wb_stb_o}, 2'b11);
    chk("wr_bus",  {wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 8'h04, 8'hA5});
    chk("wr_gnt",  gnt_o, 2'b01);
    m_adr[7:0] = 8'hEE;  // latched copy must not follow
    tick();
    chk("wr_stable", {wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 8'h04, 8'hA5});
    ack(0, 8'h5A);
    chk("wr_ackdat", {m_ack_o, m_dat_o}, {2'b01, 8'h5A});
    chk("wr_down",   {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("wr_hold_gnt", gnt_o, 2'b01);
    drop(0);
    tick();
    chk("wr_gnt_clr", gnt_o, 2'b00);

    // Ack while idle is ignored.
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("idle_ack", {m_ack_o, gnt_o, wb_cyc_o}, 5'b0);
    tick();

    // Simultaneous after reset: req0 first; re-request from req0 then loses.
    do_reset();
    req(0, 1'b0, 8'h10, 8'h00);
    req(1, 1'b0, 8'h20, 8'h00);
    tick();
    chk("rr_first",  {gnt_o, wb_adr_o}, {2'b01, 8'h10});
    ack(0, 8'h11);
    drop(0);
    tick();
    chk("rr_idle", gnt_o, 2'b00);
    req(0, 1'b0, 8'h10, 8'h00);
    tick();
    chk("rr_second", {gnt_o, wb_adr_o, wb_we_o}, {2'b10, 8'h20, 1'b0});
    ack(1, 8'h22);
    drop(1);
    tick();
    tick();
    chk("rr_third", {gnt_o, wb_adr_o}, {2'b01, 8'h10});
    ack(0, 8'h33);
    drop(0);
    tick();

    // Read from requester 1.
    req(1, 1'b0, 8'h02, 8'h00);
    tick();
    chk("rd_bus", {gnt_o, wb_adr_o, wb_we_o}, {2'b10, 8'h02, 1'b0});
    ack(1, 8'h3C);
    chk("rd_data", {m_ack_o, m_dat_o}, {2'b10, 8'h3C});
    drop(1);
    tick();

    // Timeout: err 8 cycles after cyc rises.
    req(0, 1'b0, 8'h07, 8'h00);
    tick();
    e.ack = 2'b00; e.err = 2'b01; e.dat = 8'hFF;
    sb.push_back(e);
    for (int k = 1; k < 8; k++) begin
      tick();
      if (m_err_o != 2'b00 || !wb_cyc_o) chk("to_early", {m_err_o, wb_cyc_o}, 3'b001);
    end
    tick();
    chk("to_err", {m_err_o, m_dat_o, wb_cyc_o}, {2'b01, 8'hFF, 1'b0});
    drop(0);
    tick();

    // Ack on the same edge as the timeout resolves as ack.
    req(0, 1'b0, 8'h08, 8'h00);
    tick();
    for (int k = 1; k < 8; k++) tick();
    ack(0, 8'h77);
    chk("to_vs_ack", {m_ack_o, m_err_o, m_dat_o}, {2'b01, 2'b00, 8'h77});
    drop(0);
    tick();

    // Abort: requester drops cyc mid-transfer.
    req(0, 1'b1, 8'h09, 8'h99);
    tick();
    tick();
    drop(0);
    tick();
    chk("abort", {wb_cyc_o, wb_stb_o, gnt_o, m_ack_o, m_err_o}, 8'h0);
    tick();
    tick();

    // Reset in the middle of a transfer.
    req(1, 1'b1, 8'h0A, 8'h55);
    tick();
    chk("rstb_busy", {wb_cyc_o, gnt_o}, 3'b110);
    rst = 1'b1;
    tick();
    chk("rst_busy", {wb_cyc_o, wb_stb_o, gnt_o, m_dat_o, wb_adr_o}, 28'h0);
    rst = 1'b0;
    drop(1);
    tick();

    // HOLD: req0 keeps stb after ack; req1 waits until req0 cyc drops.
    req(0, 1'b1, 8'h0B, 8'h12);
    req(1, 1'b1, 8'h0C, 8'h34);
    tick();
    chk("hold_g0", gnt_o, 2'b01);
    ack(0, 8'h01);
    tick();
    chk("hold_noreq", {wb_cyc_o, gnt_o}, 3'b001);
    drop(0);
    tick();
    chk("hold_exit", {wb_cyc_o, gnt_o}, 3'b000);
    tick();
    chk("hold_g1", {wb_cyc_o, gnt_o, wb_adr_o, wb_dat_o}, {1'b1, 2'b10, 8'h0C, 8'h34});
    ack(1, 8'h02);
    drop(1);
    tick();
    tick();

    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/can_wb_arbiter.md
CAN_WB_ARBITER -- requirements
Module: can_wb_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; clock port wb_clk_i, reset port wb_rst_i.
REQ-002 Parameter TIMEOUT, default 1000, SHALL set the number of wb_clk_i cycles without wb_ack_i before a granted cycle is aborted with error.
REQ-003 The block SHALL expose these ports:
- wb_clk_i  in  1  core/bus clock
- wb_rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  2  per-requester cycle; bit r = requester r
- m_stb_i  in  2  per-requester strobe
- m_we_i  in  2  per-requester write enable
- m_adr_i  in  16  requester r address in bits [8r+7:8r]
- m_dat_i  in  16  requester r write data in bits [8r+7:8r]
- m_dat_o  out  8  read data, shared, valid with m_ack_o
- m_ack_o  out  2  one-cycle ack to requester r
- m_err_o  out  2  one-cycle timeout error to requester r
- gnt_o  out  2  one-hot current grant, 0 when idle
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  to CAN core
- wb_adr_o, wb_dat_o  out  8 each  to CAN core
- wb_dat_i  in  8  read data from CAN core
- wb_ack_i  in  1  ack from CAN core

Function
REQ-004 The FSM SHALL have states IDLE, BUSY, HOLD.
REQ-005 In IDLE, a request is m_cyc_i[r] & m_stb_i[r]; if any is present at edge N, the arbiter SHALL latch winner r's we/adr/dat, set gnt_o, and enter BUSY with wb_cyc_o=wb_stb_o=1 at N+1.
REQ-006 Winner selection SHALL be round-robin: the requester not granted last wins on simultaneous requests; after reset requester 0 has priority.
REQ-007 wb_we_o/wb_adr_o/wb_dat_o SHALL be driven from the latched copy and remain stable throughout BUSY.
REQ-008 In BUSY, wb_ack_i=1 at edge M SHALL produce m_ack_o[r]=1 for exactly one cycle at M+1, m_dat_o=captured wb_dat_i (for writes too), wb_cyc_o=wb_stb_o=0 at M+1, and a transition to HOLD.
REQ-009 In BUSY, a 16-bit cycle counter SHALL increment each cycle; on reaching TIMEOUT with no ack, m_err_o[r] SHALL pulse one cycle, m_dat_o=8'hFF, wb_cyc_o/wb_stb_o drop, state goes to HOLD.
REQ-010 An ack and the timeout on the same edge SHALL resolve as ack; no m_err_o.
REQ-011 If m_cyc_i[r] drops during BUSY (abort), wb_cyc_o/wb_stb_o SHALL drop next cycle, no ack/err issued, state returns to IDLE.
REQ-012 HOLD SHALL persist until m_cyc_i[r]=0, then return to IDLE; gnt_o clears on leaving HOLD; a lingering m_stb_i from the served requester SHALL NOT start a new cycle.
REQ-013 Requests from the non-granted requester SHALL be held off (no ack/err) until arbitration in IDLE.
REQ-014 wb_ack_i outside BUSY SHALL be ignored.
REQ-015 Minimum turnaround SHALL be: request N, downstream cyc N+1, ack earliest N+2, m_ack_o N+3.

Reset
REQ-016 While wb_rst_i=1 at an edge: state IDLE, counter 0, round-robin pointer favoring requester 0, all outputs 0 (m_dat_o=8'h00).
REQ-017 Reset asserted mid-BUSY SHALL drop wb_cyc_o/wb_stb_o next edge with no ack/err to the requester.

Structure
REQ-018 Package can_arb_pkg SHALL hold the state enum, NUM_REQ=2, DEFAULT_TIMEOUT=1000 and counter width.
REQ-019 Round-robin selection SHALL be a sub-module can_rr_pick (request vector + last-grant in, one-hot grant out, combinational).

Verification
REQ-020 Single write: req0 writes adr 8'h04 data 8'hA5, core acks 2 cycles later -> wb_adr_o=04/wb_dat_o=A5/wb_we_o=1, one m_ack_o[0] pulse, gnt_o=01 then 00.
REQ-021 Simultaneous requests after reset: both raise cyc/stb at the same edge -> req0 served first, then req1; repeat -> req1 first.
REQ-022 Read data: req1 reads adr 8'h02, core returns 8'h3C with ack -> m_dat_o=3C with m_ack_o[1]=1 for one cycle.
REQ-023 Timeout: TIMEOUT=8, core never acks -> m_err_o[0] pulse 8 cycles after wb_cyc_o rise, m_dat_o=FF, wb_cyc_o low.
REQ-024 Abort and reset: req0 drops cyc mid-BUSY -> downstream drops next cycle, no ack; wb_rst_i mid-BUSY -> all outputs 0 next edge.
REQ-025 HOLD: req0 holds stb one cycle after ack -> no second downstream cycle; req1 pending is granted after req0 cyc drops.
